// File: rtl/period_meter_pkg.sv
// Shared types and constants for the period meter.
package period_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_COUNT = 2'd2,
    ST_DONE  = 2'd3
  } pm_state_t;

  localparam logic MODE_PERIOD = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

  // Edge counter width; covers N_PER up to 16.
  localparam int E_W = 5;

  // Bits needed to hold a tick-divider count of 0..div-1.
  function automatic int tick_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/pm_edge_detect.sv
// Edge detector for the measured signal.
// With PERIOD_METER_SYNC_EN defined, si first passes a 2-flop
// synchroniser (2 extra cycles of edge latency); otherwise si must
// already be synchronous to clk.
module pm_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic si,
  output logic rise,
  output logic fall
);

  logic si_in;
  logic si_q;
  logic si_prev;

`ifdef PERIOD_METER_SYNC_EN
  logic sync_1;
  logic sync_2;

  // Two-flop synchroniser for the asynchronous input.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_1 <= 1'b0;
      sync_2 <= 1'b0;
    end else begin
      sync_1 <= si;
      sync_2 <= sync_1;
    end
  end

  assign si_in = sync_2;
`else
  assign si_in = si;
`endif

  // Registered sample and its previous value for edge comparison.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      si_q    <= 1'b0;
      si_prev <= 1'b0;
    end else begin
      si_q    <= si_in;
      si_prev <= si_q;
    end
  end

  assign rise = si_q & ~si_prev;
  assign fall = ~si_q & si_prev;

endmodule

// File: rtl/period_meter.sv
// Period / pulse-width meter measuring si in ticks of TICK_DIV clocks.
// Optional input synchroniser: define PERIOD_METER_SYNC_EN.
//
//   state    | meaning
//   ---------+------------------------------------------------------
//   ST_IDLE  | ready, waiting for start; mode latched on start
//   ST_WAIT  | waiting for the rising edge that opens the interval
//   ST_COUNT | counting ticks until the terminating edge
//   ST_DONE  | one-cycle done_tick, then back to ST_IDLE
module period_meter
  import period_meter_pkg::*;
#(
  parameter int TICK_DIV = 50000,
  parameter int CNT_W    = 10,
  parameter int N_PER    = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             mode,
  input  logic             abort,
  input  logic             si,
  output logic             ready,
  output logic             done_tick,
  output logic             ovf,
  output logic [CNT_W-1:0] prd
);

  localparam int             T_W    = tick_width(TICK_DIV);
  localparam logic [T_W-1:0] T_LAST = T_W'(TICK_DIV - 1);
  localparam logic [E_W-1:0] E_LAST = E_W'(N_PER);

  pm_state_t        state;
  pm_state_t        state_nxt;
  logic             mode_q;
  logic [T_W-1:0]   t;
  logic [CNT_W-1:0] p;
  logic [E_W-1:0]   e;
  logic [E_W-1:0]   e_inc;
  logic             ovf_q;

  logic si_rise;
  logic si_fall;
  logic load_mode;
  logic start_meas;
  logic tick_en;
  logic edge_inc;

  pm_edge_detect u_edge (
    .clk   (clk),
    .reset (reset),
    .si    (si),
    .rise  (si_rise),
    .fall  (si_fall)
  );

  assign e_inc = e + E_W'(1);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and datapath strobes; abort beats the terminating edge,
  // and a terminating edge suppresses the tick of that same cycle.
  always_comb begin
    state_nxt  = state;
    load_mode  = 1'b0;
    start_meas = 1'b0;
    tick_en    = 1'b0;
    edge_inc   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_nxt = ST_WAIT;
          load_mode = 1'b1;
        end
      end
      ST_WAIT: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (si_rise) begin
          state_nxt  = ST_COUNT;
          start_meas = 1'b1;
        end
      end
      ST_COUNT: begin
        if (abort) begin
          state_nxt = ST_IDLE;
        end else if (mode_q == MODE_PULSE) begin
          if (si_fall) state_nxt = ST_DONE;
          else         tick_en   = 1'b1;
        end else begin
          if (si_rise && (e_inc == E_LAST)) begin
            state_nxt = ST_DONE;
          end else begin
            edge_inc = si_rise;
            tick_en  = 1'b1;
          end
        end
      end
      ST_DONE: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Measurement datapath: mode latch, tick divider, saturating result,
  // edge counter. The opening edge was seen in the WAIT->COUNT cycle, so
  // that cycle already belongs to the interval and t restarts at 1; this
  // keeps the count edge-to-edge and the result floor(cycles/TICK_DIV).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode_q <= MODE_PERIOD;
      t      <= '0;
      p      <= '0;
      e      <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (load_mode) mode_q <= mode;
      if (start_meas) begin
        t     <= T_W'(1);
        p     <= '0;
        e     <= '0;
        ovf_q <= 1'b0;
      end else begin
        if (edge_inc) e <= e_inc;
        if (tick_en) begin
          if (t == T_LAST) begin
            t <= '0;
            if (p == {CNT_W{1'b1}}) ovf_q <= 1'b1;
            else                    p     <= p + CNT_W'(1);
          end else begin
            t <= t + T_W'(1);
          end
        end
      end
    end
  end

  assign ready     = (state == ST_IDLE);
  assign done_tick = (state == ST_DONE);
  assign prd       = p;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_period_meter.sv
// Testbench for period_meter: two instances (N_PER=1 and N_PER=4),
// expected results queued at stimulus time and compared on done_tick.
module tb_period_meter;

  localparam int TICK = 10;
  localparam int W    = 4;
  localparam int MAXP = (1 << W) - 1;
`ifdef PERIOD_METER_SYNC_EN
  localparam int LAT = 4;
`else
  localparam int LAT = 2;
`endif

  typedef struct {
    int   d;
    int   prd;
    logic ovf;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start [2];
  logic         mode [2];
  logic         abort [2];
  logic         si [2];
  logic         ready [2];
  logic         done_tick [2];
  logic         ovf [2];
  logic [W-1:0] prd [2];

  int   cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   done_cnt [2] = '{0, 0};
  int   done_cyc [2] = '{0, 0};
  logic prev_done [2] = '{1'b0, 1'b0};
  int   last_prd [2] = '{0, 0};
  logic last_ovf [2] = '{1'b0, 1'b0};
  exp_t sb [$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  period_meter #(.TICK_DIV(TICK), .CNT_W(W), .N_PER(1)) dut_a (
    .clk(clk), .reset(reset), .start(start[0]), .mode(mode[0]),
    .abort(abort[0]), .si(si[0]), .ready(ready[0]),
    .done_tick(done_tick[0]), .ovf(ovf[0]), .prd(prd[0])
  );

  period_meter #(.TICK_DIV(TICK), .CNT_W(W), .N_PER(4)) dut_b (
    .clk(clk), .reset(reset), .start(start[1]), .mode(mode[1]),
    .abort(abort[1]), .si(si[1]), .ready(ready[1]),
    .done_tick(done_tick[1]), .ovf(ovf[1]), .prd(prd[1])
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  // Scoreboard side: every done_tick pops one expected result.
  always @(negedge clk) begin
    exp_t ex;
    for (int d = 0; d < 2; d++) begin
      if (prev_done[d] === 1'b1) check("ready_after_done", 32'(ready[d]), 1);
      if (done_tick[d] === 1'b1) begin
        done_cnt[d]++;
        done_cyc[d] = cyc;
        check("ready_in_done", 32'(ready[d]), 0);
        if (sb.size() == 0) begin
          check("unexpected_done", 1, 0);
        end else begin
          ex = sb.pop_front();
          check("done_unit", d, ex.d);
          check("prd", 32'(prd[d]), ex.prd);
          check("ovf", 32'(ovf[d]), 32'(ex.ovf));
        end
      end
      prev_done[d] = done_tick[d];
    end
  end

  // One measurement: mode 0 drives reps periods of (hi+lo) between reps+1
  // rising edges; mode 1 drives a single high pulse of hi cycles.
  task automatic run_meas(input int d, input logic m, input int hi, input int lo,
                          input int reps, input logic pre_high);
    int   n, ticks, base, term_cyc, k;
    exp_t ex;
    n        = m ? hi : reps * (hi + lo);
    ticks    = n / TICK;
    ex.d     = d;
    ex.prd   = (ticks > MAXP) ? MAXP : ticks;
    ex.ovf   = (ticks > MAXP);
    term_cyc = 0;
    k = 0;
    while (ready[d] !== 1'b1 && k < 200) begin
      @(negedge clk);
      k++;
    end
    check("ready_before_start", 32'(ready[d]), 1);
    if (pre_high) begin
      si[d] = 1'b1;
      repeat (5) @(negedge clk);
    end
    sb.push_back(ex);
    base = done_cnt[d];
    start[d] = 1'b1;
    mode[d]  = m;
    @(negedge clk);
    start[d] = 1'b0;
    mode[d]  = ~m;
    repeat (5) @(negedge clk);
    check("ready_in_wait", 32'(ready[d]), 0);
    if (pre_high) begin
      check("wait_hold_prd", 32'(prd[d]), last_prd[d]);
      check("wait_hold_ovf", 32'(ovf[d]), 32'(last_ovf[d]));
      si[d] = 1'b0;
      repeat (5) @(negedge clk);
    end
    for (int r = 0; r < reps; r++) begin
      si[d] = 1'b1;
      repeat (hi) @(negedge clk);
      si[d] = 1'b0;
      if (m) term_cyc = cyc;
      repeat (lo) @(negedge clk);
    end
    si[d] = 1'b1;
    if (!m) term_cyc = cyc;
    repeat (hi) @(negedge clk);
    si[d] = 1'b0;
    k = 0;
    while (done_cnt[d] == base && k < 300) begin
      @(negedge clk);
      k++;
    end
    check("done_seen", done_cnt[d] - base, 1);
    check("done_latency", done_cyc[d] - term_cyc, LAT);
    repeat (5) @(negedge clk);
    check("prd_hold", 32'(prd[d]), ex.prd);
    check("ovf_hold", 32'(ovf[d]), 32'(ex.ovf));
    last_prd[d] = ex.prd;
    last_ovf[d] = ex.ovf;
  endtask

  initial begin
    int base;
    for (int i = 0; i < 2; i++) begin
      start[i] = 1'b0;
      mode[i]  = 1'b0;
      abort[i] = 1'b0;
      si[i]    = 1'b0;
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      check("rst_ready", 32'(ready[i]), 1);
      check("rst_done", 32'(done_tick[i]), 0);
      check("rst_prd", 32'(prd[i]), 0);
      check("rst_ovf", 32'(ovf[i]), 0);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    run_meas(0, 1'b0, 25, 25, 1, 1'b0);   // period 50 -> 5
    run_meas(0, 1'b0, 10, 33, 1, 1'b1);   // si high entering WAIT, period 43 -> 4
    run_meas(1, 1'b0, 15, 15, 4, 1'b0);   // 4 periods of 30 -> 12
    run_meas(0, 1'b1, 25, 75, 1, 1'b0);   // pulse 25 -> 2
    run_meas(1, 1'b1, 37, 20, 1, 1'b0);   // pulse mode ignores N_PER -> 3
    run_meas(0, 1'b0, 5, 4, 1, 1'b0);     // 9: edge beats wrap -> 0
    run_meas(0, 1'b0, 5, 5, 1, 1'b0);     // 10 -> 1
    run_meas(0, 1'b0, 10, 9, 1, 1'b0);    // 19: edge beats wrap -> 1
    run_meas(0, 1'b0, 100, 100, 1, 1'b0); // 200 -> saturate 15, ovf
    run_meas(0, 1'b0, 10, 20, 1, 1'b1);   // ovf/prd held through WAIT -> 3

    // abort 20 cycles into COUNT
    @(negedge clk);
    start[0] = 1'b1;
    mode[0]  = 1'b0;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (3) @(negedge clk);
    si[0] = 1'b1;
    repeat (LAT) @(negedge clk);
    check("abort_in_count", 32'(ready[0]), 0);
    check("count_prd_cleared", 32'(prd[0]), 0);
    repeat (20) @(negedge clk);
    base = done_cnt[0];
    abort[0] = 1'b1;
    @(negedge clk);
    abort[0] = 1'b0;
    check("abort_ready", 32'(ready[0]), 1);
    check("abort_prd", 32'(prd[0]), 20 / TICK);
    check("abort_ovf", 32'(ovf[0]), 0);
    si[0] = 1'b0;
    repeat (30) @(negedge clk);
    si[0] = 1'b1;
    repeat (30) @(negedge clk);
    si[0] = 1'b0;
    repeat (10) @(negedge clk);
    check("abort_no_done", done_cnt[0] - base, 0);
    check("abort_prd_hold", 32'(prd[0]), 20 / TICK);
    last_prd[0] = 20 / TICK;
    last_ovf[0] = 1'b0;

    run_meas(0, 1'b0, 20, 20, 1, 1'b0);   // after abort, 40 -> 4

    // reset while saturated mid-COUNT
    @(negedge clk);
    start[0] = 1'b1;
    mode[0]  = 1'b0;
    @(negedge clk);
    start[0] = 1'b0;
    repeat (3) @(negedge clk);
    si[0] = 1'b1;
    repeat (LAT) @(negedge clk);
    repeat (175) @(negedge clk);
    check("pre_rst_prd", 32'(prd[0]), MAXP);
    check("pre_rst_ovf", 32'(ovf[0]), 1);
    base = done_cnt[0];
    #2;
    reset = 1'b1;
    #1;
    check("midrst_ready", 32'(ready[0]), 1);
    check("midrst_done", 32'(done_tick[0]), 0);
    check("midrst_prd", 32'(prd[0]), 0);
    check("midrst_ovf", 32'(ovf[0]), 0);
    check("midrst_prd_b", 32'(prd[1]), 0);
    si[0] = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("midrst_no_done", done_cnt[0] - base, 0);
    last_prd[0] = 0;
    last_prd[1] = 0;
    last_ovf[0] = 1'b0;
    last_ovf[1] = 1'b0;

    run_meas(0, 1'b0, 12, 12, 1, 1'b0);   // after reset, 24 -> 2

    repeat (5) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
